// File: rtl/program_launcher_pkg.sv
// Shared selector codes, launcher FSM states and counter sizing helper for the
// program-select front end; the processor top imports the same selector codes.
package program_launcher_pkg;

    localparam int unsigned PROG_CODE_W = 3;

    localparam logic [PROG_CODE_W-1:0] PROG_NONE = 3'd0;
    localparam logic [PROG_CODE_W-1:0] PROG_FIB  = 3'd1;
    localparam logic [PROG_CODE_W-1:0] PROG_SORT = 3'd2;
    localparam logic [PROG_CODE_W-1:0] PROG_SAVE = 3'd3;
    localparam logic [PROG_CODE_W-1:0] PROG_LOAD = 3'd4;

    // Button vector bit positions.
    localparam int unsigned BTN_FIB  = 0;
    localparam int unsigned BTN_SORT = 1;
    localparam int unsigned BTN_SAVE = 2;
    localparam int unsigned BTN_LOAD = 3;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_RELEASE
    } launch_state_e;

    // Counter width for a terminal count of n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Fixed priority fib > sort > save > load; lower-priority requests are lost.
    function automatic logic [PROG_CODE_W-1:0] encode_priority(input logic [3:0] req);
        if (req[BTN_FIB])       return PROG_FIB;
        else if (req[BTN_SORT]) return PROG_SORT;
        else if (req[BTN_SAVE]) return PROG_SAVE;
        else if (req[BTN_LOAD]) return PROG_LOAD;
        else                    return PROG_NONE;
    endfunction

endpackage

// File: rtl/program_launcher_button_debounce.sv
// Two-flop synchroniser, counter debouncer and rising-edge detector for one
// raw board button.
module button_debounce
    import program_launcher_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic rise
);

    localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             db_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            db_q  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            // Any sample agreeing with db restarts the run, so short glitches never flip it.
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = db & ~db_q;

endmodule

// File: rtl/program_launcher.sv
// Turns four raw buttons into one held program_selector command with a switch
// snapshot; extra presses while busy are dropped and flagged.
module program_launcher
    import program_launcher_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 4,
    parameter int unsigned SEL_WIDTH       = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 btn_fib,
    input  logic                 btn_sort,
    input  logic                 btn_save,
    input  logic                 btn_load,
    input  logic [15:0]          sw,
    output logic [SEL_WIDTH-1:0] program_selector,
    output logic [15:0]          sw_snapshot,
    output logic                 busy,
    output logic                 dropped_cmd
);

    localparam int unsigned       HOLD_W    = cnt_width(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [3:0]        raw;
    logic [3:0]        db;
    logic [3:0]        rise;
    launch_state_e     state;
    logic [HOLD_W-1:0] hold_cnt;

    assign raw[BTN_FIB]  = btn_fib;
    assign raw[BTN_SORT] = btn_sort;
    assign raw[BTN_SAVE] = btn_save;
    assign raw[BTN_LOAD] = btn_load;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock(clock),
            .reset(reset),
            .raw  (raw[i]),
            .db   (db[i]),
            .rise (rise[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            hold_cnt         <= '0;
            program_selector <= '0;
            sw_snapshot      <= '0;
            busy             <= 1'b0;
            dropped_cmd      <= 1'b0;
        end else begin
            dropped_cmd <= 1'b0;
            case (state)
                IDLE: begin
                    if (|rise) begin
                        program_selector <= SEL_WIDTH'(encode_priority(rise));
                        sw_snapshot      <= sw;
                        hold_cnt         <= HOLD_LAST;
                        busy             <= 1'b1;
                        state            <= HOLD;
                    end
                end
                HOLD: begin
                    if (|rise) dropped_cmd <= 1'b1;
                    if (hold_cnt == '0) begin
                        program_selector <= '0;
                        state            <= WAIT_RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    if (|rise) dropped_cmd <= 1'b1;
                    if (db == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
